neuron_mac: RTL and testbench

//  Sequential multiply-accumulate neuron: streams NUM_INPUTS (activation, weight) pairs, adds a bias,

---
 rtl/nn_pkg.sv | 9 +
 rtl/mac_mult.sv | 22 ++
 rtl/neuron_mac.sv | 86 ++++++++
 tb/tb_neuron_mac.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, FSM state encoding and saturation limits for the neuron datapath
package nn_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int ACT_W = 2 * DEF_WIDTH;
  localparam int ACC_W = 4 * DEF_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mac_mult.sv
// mac_mult: registered signed multiplier with valid pass-through
module mac_mult #(
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic                 out_vld,
  output logic signed [2*AW-1:0] p
);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      p <= '0;
    end else begin
      out_vld <= in_vld;
      p <= in_vld ? a * b : p;
    end
  end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate neuron with bias; NEURON_MAC_SAT_EN selects saturating accumulation
module neuron_mac
  import nn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_INPUTS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   data_in,
  input  logic [2*WIDTH-1:0]   weight_in,
  input  logic [4*WIDTH-1:0]   bias_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   data_out,
  output logic                 busy
);
  localparam int AW = 2 * WIDTH;
  localparam int SW = 4 * WIDTH;
  localparam int CW = $clog2(NUM_INPUTS);
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);
  if (NUM_INPUTS < 2) begin : g_chk
    $error("neuron_mac: NUM_INPUTS must be at least 2");
  end
  state_t state;
  logic [CW-1:0] beat_cnt;
  logic signed [SW-1:0] acc, prod, acc_nxt;
  logic prod_vld, accept, first;
  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  assign first = accept && state == IDLE;
  mac_mult #(.AW(AW)) u_mult (
    .clk(clk),
    .rst(rst),
    .in_vld(accept),
    .a(data_in),
    .b(weight_in),
    .out_vld(prod_vld),
    .p(prod)
  );
`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};
  logic signed [SW:0] wide;
  logic ovf, sat;
  assign wide = {acc[SW-1], acc} + {prod[SW-1], prod};
  assign ovf = wide[SW] != wide[SW-1];
  assign acc_nxt = ovf ? (wide[SW] ? SMIN : SMAX) : wide[SW-1:0];
  always_ff @(posedge clk) begin
    if (rst) sat <= 1'b0;
    else sat <= first ? 1'b0 : sat | (prod_vld & ovf);
  end
`else
  assign acc_nxt = acc + prod;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      data_out <= '0;
    end else begin
      // bias seeds the accumulator one cycle ahead of the first product
      acc <= first ? bias_in : prod_vld ? acc_nxt : acc;
      if (accept) beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
      case (state)
        IDLE: if (accept) state <= ACCUM;
        ACCUM: if (accept && beat_cnt == LAST) state <= FLUSH;
        FLUSH: begin
          state <= DONE;
          out_valid <= 1'b1;
          data_out <= acc_nxt;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed table-driven checks of neuron_mac (WIDTH=8, NUM_INPUTS=4)
module tb_neuron_mac;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] data_in, weight_in;
  logic [31:0] bias_in, data_out;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0][15:0] d;
    logic [3:0][15:0] w;
    logic [31:0] b;
    logic [31:0] e;
    int gap;
    int bp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  neuron_mac #(.WIDTH(8), .NUM_INPUTS(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .weight_in(weight_in),
    .bias_in(bias_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, w0, w1, w2, w3,
                              input logic [31:0] b, e, input int gap, bp);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.b = b;
    v.e = e;
    v.gap = gap;
    v.bp = bp;
    return v;
  endfunction

  task automatic run(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      data_in = v.d[i];
      weight_in = v.w[i];
      bias_in = (i == 0) ? v.b : 32'hDEADBEEF;
      chk("in_ready_beat", {31'd0, in_ready}, 32'd1);
      step();
      if (i == 0) chk("busy_accum", {31'd0, busy}, 32'd1);
      if (v.gap > 0 && i < 3) begin
        in_valid = 1'b0;
        data_in = 16'h7FFF;
        weight_in = 16'h7FFF;
        repeat (v.gap) step();
      end
    end
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_data_out", data_out, v.e);
    if (v.bp > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      data_in = 16'h7FFF;
      weight_in = 16'h7FFF;
      repeat (v.bp) begin
        step();
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_data_out", data_out, v.e);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    step();
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0200,
                 32'h0, 32'h00080000, 0, 0);
    vecs[1] = mk(16'h0100, 16'hFF00, 16'h0200, 16'h0080, 16'h0100, 16'h0100, 16'hFF00, 16'h0400,
                 32'h00001000, 32'h00001000, 0, 0);
    vecs[2] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0200,
                 32'h0, 32'h00080000, 1, 5);
`ifdef NEURON_MAC_SAT_EN
    vecs[3] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0);
`else
    vecs[3] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 32'h7FFFFFFF, 32'h7FFC0003, 0, 0);
`endif
    vecs[4] = vecs[1];
    vecs[5] = vecs[0];
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    data_in = '0;
    weight_in = '0;
    bias_in = '0;
    repeat (2) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 6; k++) run(vecs[k]);
    in_valid = 1'b1;
    data_in = 16'h7FFF;
    weight_in = 16'h7FFF;
    bias_in = 32'h12345678;
    repeat (2) step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data_out", data_out, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    run(vecs[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
